id_ex_pipe: RTL and testbench

Parametrised successor to the fixed ID/EX pipeline register. Carries packed control (WB/M/EX) and data (npc, rd1, rd2, imm, rt, rd) from decode to execute. Adds a valid/ready handshake with an optional skid entry, synchronous flush, and control zeroing on bubbles. Includes a saturating stall-cycle counter for hazard-unit debug.

---
 rtl/id_ex_pipe.sv | 114 +++++++++++
 tb/tb_id_ex_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: carries the packed decode control and data bundles to
// execute behind a valid/ready handshake. With SKID=1 a second entry absorbs
// one extra transfer so in_ready can come straight from a flop. It also
// supports a synchronous flush and a saturating stall counter for
// hazard-unit debug.
module id_ex_pipe #(
    parameter int CTL_W  = 9,
    parameter int DATA_W = 138,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Main entry M (visible on out_*) and skid entry S (held behind M)
    logic              m_valid;
    logic [CTL_W-1:0]  m_ctl;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic [CTL_W-1:0]  s_ctl;
    logic [DATA_W-1:0] s_data;

    logic in_fire;
    logic out_fire;
    logic m_free;

    // Handshake: skid mode takes in_ready from a flop; single-entry mode
    // lets the downstream ready pass straight through.
    always_comb begin
        if (SKID != 0) begin
            in_ready = !s_valid;
        end else begin
            in_ready = !m_valid || out_ready;
        end
        in_fire   = in_valid && in_ready;
        out_valid = m_valid;
        out_fire  = m_valid && out_ready;
        m_free    = !m_valid || out_fire;
        out_ctl   = m_valid ? m_ctl : '0;
        out_data  = m_data;
    end

    // Entry movement: S always drains into M before new input can reach M,
    // which keeps instruction order intact. Flush kills validity only;
    // the stale payload stays in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_ctl   <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ctl   <= '0;
            s_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (SKID != 0) begin
            if (m_free) begin
                if (s_valid) begin
                    m_valid <= 1'b1;
                    m_ctl   <= s_ctl;
                    m_data  <= s_data;
                    s_valid <= 1'b0;
                end else if (in_fire) begin
                    m_valid <= 1'b1;
                    m_ctl   <= in_ctl;
                    m_data  <= in_data;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (in_fire) begin
                s_valid <= 1'b1;
                s_ctl   <= in_ctl;
                s_data  <= in_data;
            end
        end else begin
            if (in_fire) begin
                m_valid <= 1'b1;
                m_ctl   <= in_ctl;
                m_data  <= in_data;
            end else if (out_fire) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Stall counter: counts cycles the held entry is refused downstream;
    // a clear wins over a simultaneous increment and the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: a SKID=1 / CNT_W=4 instance is the main
// target; a SKID=0 instance shares the inputs for the single-entry mode.
module tb_id_ex_pipe;

    localparam int CTL_W  = 9;
    localparam int DATA_W = 138;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [CTL_W-1:0]  in_ctl;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              flush;
    logic              cnt_clr;

    logic              in_ready;
    logic              out_valid;
    logic [CTL_W-1:0]  out_ctl;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        stall_cnt;

    logic              n_in_ready;
    logic              n_out_valid;
    logic [CTL_W-1:0]  n_out_ctl;
    logic [DATA_W-1:0] n_out_data;
    logic [15:0]       n_stall_cnt;

    int n_checks;
    int n_fail;

    id_ex_pipe #(.CTL_W(CTL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctl(in_ctl), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctl(out_ctl), .out_data(out_data),
        .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    id_ex_pipe #(.CTL_W(CTL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)) u_nsk (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_ctl(in_ctl), .in_data(in_data), .out_valid(n_out_valid),
        .out_ready(out_ready), .out_ctl(n_out_ctl), .out_data(n_out_data),
        .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(n_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {npc, rd1, rd2, imm, rt, rd} = {b, b+1, b+2, b+3, b+4, b+5}
    function automatic logic [DATA_W-1:0] mk(input int b);
        return {32'(b), 32'(b + 1), 32'(b + 2), 32'(b + 3), 5'(b + 4), 5'(b + 5)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTL_W-1:0] c, input int b);
        in_valid = v;
        in_ctl   = c;
        in_data  = mk(b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_ctl = '0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_ctl !== '0) begin n_fail++; $display("FAIL reset_out_ctl: got %h want 0", out_ctl); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b1, 9'h0A3, 4);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready0: got %b want 1", in_ready); end
        step();
        drive(1'b0, '0, 0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        n_checks++; if (out_ctl !== 9'h0A3) begin n_fail++; $display("FAIL basic_out_ctl: got %h want 0a3", out_ctl); end
        n_checks++; if (out_data !== mk(4)) begin n_fail++; $display("FAIL basic_out_data: got %h want %h", out_data, mk(4)); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready1: got %b want 1", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_valid: got %b want 0", out_valid); end
        n_checks++; if (out_ctl !== '0) begin n_fail++; $display("FAIL basic_bubble_ctl: got %h want 0", out_ctl); end
        n_checks++; if (out_data !== mk(4)) begin n_fail++; $display("FAIL basic_hold_data: got %h want %h", out_data, mk(4)); end
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL basic_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(1'b1, 9'h011, 32'h100);
        step();
        n_checks++; if (out_ctl !== 9'h011) begin n_fail++; $display("FAIL skid_a_ctl: got %h want 011", out_ctl); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_after_a: got %b want 1", in_ready); end
        drive(1'b1, 9'h022, 32'h200);
        step();
        n_checks++; if (out_data !== mk(32'h100)) begin n_fail++; $display("FAIL skid_a_held: got %h want %h", out_data, mk(32'h100)); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_ready_after_b: got %b want 0", in_ready); end
        drive(1'b1, 9'h033, 32'h300);
        step();
        n_checks++; if (out_ctl !== 9'h011) begin n_fail++; $display("FAIL skid_a_still: got %h want 011", out_ctl); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_c_refused: got %b want 0", in_ready); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_ctl !== 9'h022 || out_data !== mk(32'h200)) begin n_fail++; $display("FAIL skid_b_out: got %h/%h want 022/%h", out_ctl, out_data, mk(32'h200)); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_reopen: got %b want 1", in_ready); end
        step();
        drive(1'b0, '0, 0);
        n_checks++; if (out_ctl !== 9'h033 || out_data !== mk(32'h300)) begin n_fail++; $display("FAIL skid_c_out: got %h/%h want 033/%h", out_ctl, out_data, mk(32'h300)); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_no_dup: got %b want 0", out_valid); end
        n_checks++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL skid_stall_cnt: got %0d want 2", stall_cnt); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL b2b_clr: got %0d want 0", stall_cnt); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 9'(9'h040 + i), 1000 + 16 * i);
            n_checks++; if (in_ready !== 1'b1 || n_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b/%b want 1/1", i, in_ready, n_in_ready); end
            step();
            n_checks++; if (out_valid !== 1'b1 || out_ctl !== 9'(9'h040 + i) || out_data !== mk(1000 + 16 * i)) begin n_fail++; $display("FAIL b2b_out[%0d]: got %b %h %h want 1 %h %h", i, out_valid, out_ctl, out_data, 9'(9'h040 + i), mk(1000 + 16 * i)); end
            n_checks++; if (n_out_valid !== 1'b1 || n_out_ctl !== 9'(9'h040 + i) || n_out_data !== mk(1000 + 16 * i)) begin n_fail++; $display("FAIL b2b_nsk_out[%0d]: got %b %h %h want 1 %h", i, n_out_valid, n_out_ctl, n_out_data, 9'(9'h040 + i)); end
        end
        drive(1'b0, '0, 0);
        step();
        n_checks++; if (out_valid !== 1'b0 || n_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b/%b want 0/0", out_valid, n_out_valid); end
        // single-entry mode: in_ready follows out_ready in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 9'h055, 32'h500);
        step();
        drive(1'b0, '0, 0);
        n_checks++; if (n_in_ready !== 1'b0) begin n_fail++; $display("FAIL nsk_ready_full: got %b want 0", n_in_ready); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (n_in_ready !== 1'b1) begin n_fail++; $display("FAIL nsk_ready_comb: got %b want 1", n_in_ready); end
        step();
        n_checks++; if (n_out_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL nsk_drain: got %b/%b want 0/0", n_out_valid, out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 9'h0A1, 32'hA00);
        step();
        drive(1'b1, 9'h0B2, 32'hB00);
        step();
        drive(1'b1, 9'h0C3, 32'hC00);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_checks++; if (out_ctl !== '0) begin n_fail++; $display("FAIL flush_ctl: got %h want 0", out_ctl); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_data !== mk(32'hA00)) begin n_fail++; $display("FAIL flush_data_kept: got %h want %h", out_data, mk(32'hA00)); end
        out_ready = 1'b1;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost: got %b want 0", out_valid); end
        // an accepted input in the flush cycle is discarded
        drive(1'b1, 9'h0D4, 32'hD00);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, 0);
        n_checks++; if (out_valid !== 1'b0 || n_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_in_fire: got %b/%b want 0/0", out_valid, n_out_valid); end
    endtask

    task automatic test_stall_sat();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 9'h077, 32'h700);
        step();
        drive(1'b0, '0, 0);
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_start: got %0d want 0", stall_cnt); end
        for (int i = 1; i <= 20; i++) begin
            step();
            n_checks++; if (stall_cnt !== 4'((i > 15) ? 15 : i)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, stall_cnt, (i > 15) ? 15 : i); end
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr_wins: got %0d want 0", stall_cnt); end
        step();
        n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL sat_resume: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 9'h088, 32'h800);
        step();
        drive(1'b0, '0, 0);
        n_checks++; if (in_ready !== 1'b0 || out_ctl !== 9'h077) begin n_fail++; $display("FAIL ar_full: got %b/%h want 0/077", in_ready, out_ctl); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        n_checks++; if (out_ctl !== '0) begin n_fail++; $display("FAIL ar_ctl: got %h want 0", out_ctl); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL ar_data: got %h want 0", out_data); end
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", stall_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_skid();
        test_back_to_back();
        test_flush();
        test_stall_sat();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
